fifo_wr_arbiter: RTL and testbench

- Credit-based write scheduler that shares the write port of the 256-bit word-packing FIFO among N_REQ requesters.
- Each requester offers a burst of 1..16 16-bit words on a 256-bit bus.
- The block picks one requester per cycle by round-robin and admits a burst only when enough free FIFO words (credits) exist.
- It drives the FIFO data/size/write-enable from registers and recovers credits from the consumer's per-word read strobe.

---
 rtl/fifo_wr_arbiter_if.sv | 32 +++
 rtl/fifo_wr_arbiter.sv | 149 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the requesters, the arbiter and the word-packing FIFO.
interface fifo_wr_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned CW    = 7
);
  logic [N_REQ-1:0]     req_valid;
  logic [4*N_REQ-1:0]   req_size;
  logic [256*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]     req_ready;
  logic [255:0]         fifo_data_o;
  logic [3:0]           fifo_size_o;
  logic                 fifo_we_o;
  logic                 rd_credit_i;
  logic [CW-1:0]        credit_o;
  logic [2:0]           grant_id_o;
  logic                 stall_o;
  logic                 credit_err_o;

  // Arbiter side
  modport master (
    input  req_valid, req_size, req_data, rd_credit_i,
    output req_ready, fifo_data_o, fifo_size_o, fifo_we_o,
           credit_o, grant_id_o, stall_o, credit_err_o
  );

  // Requester / FIFO side
  modport slave (
    output req_valid, req_size, req_data, rd_credit_i,
    input  req_ready, fifo_data_o, fifo_size_o, fifo_we_o,
           credit_o, grant_id_o, stall_o, credit_err_o
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Credit-based round-robin write scheduler for the 256-bit word-packing FIFO.
module fifo_wr_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned CAPACITY = 64,
  parameter int unsigned CW       = 7
) (
  input logic              clk,
  input logic              reset_n,
  fifo_wr_arbiter_if.master bus
);
  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned NW = (CW > 5) ? CW : 5;
  localparam int unsigned SW = NW + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]    state, state_next;
  logic [IW-1:0] rr_ptr, lock, lock_next, cand, idx, acc_id;
  logic          found, accept;
  logic [4:0]    acc_need;
  logic [CW-1:0] credit;
  logic [SW-1:0] credit_sum;
  logic          over;
  logic          err;
  logic          stall;
  logic          fifo_we;
  logic [255:0]  fifo_data;
  logic [3:0]    fifo_size;
  logic [2:0]    grant_id;

  logic [4:0]    need_arr [N_REQ];
  logic [3:0]    size_arr [N_REQ];
  logic [255:0]  data_arr [N_REQ];

  // Burst length in words; a size field of zero encodes a full 16-word burst
  function automatic logic [4:0] need_of(input logic [3:0] sz);
    return (sz == 4'd0) ? 5'd16 : {1'b0, sz};
  endfunction

  // Unpack the flat requester buses into per-requester views
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      size_arr[i] = bus.req_size[4*i +: 4];
      need_arr[i] = need_of(bus.req_size[4*i +: 4]);
      data_arr[i] = bus.req_data[256*i +: 256];
    end
  end

  // Round-robin search for the first valid requester starting at rr_ptr
  always_comb begin
    found = 1'b0;
    cand  = '0;
    idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = IW'((32'(rr_ptr) + k) % N_REQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        cand  = idx;
      end
    end
  end

  // Next-state and grant decode; WAIT holds the locked head to avoid starving long bursts
  always_comb begin
    state_next    = state;
    lock_next     = lock;
    bus.req_ready = '0;
    accept        = 1'b0;
    acc_id        = '0;
    acc_need      = '0;
    case (state)
      IDLE: begin
        if (found) begin
          if (NW'(credit) >= NW'(need_arr[cand])) begin
            bus.req_ready[cand] = 1'b1;
            accept              = 1'b1;
            acc_id              = cand;
            acc_need            = need_arr[cand];
          end else begin
            state_next = WAIT;
            lock_next  = cand;
          end
        end
      end
      WAIT: begin
        if (!bus.req_valid[lock]) begin
          state_next = IDLE;
        end else if (NW'(credit) >= NW'(need_arr[lock])) begin
          bus.req_ready[lock] = 1'b1;
          accept              = 1'b1;
          acc_id              = lock;
          acc_need            = need_arr[lock];
          state_next          = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!reset_n) begin
      bus.req_ready = '0;
      accept        = 1'b0;
    end
  end

  // Credit arithmetic: same-cycle spend and return both apply, returns saturate at capacity
  always_comb begin
    credit_sum = SW'(credit) - SW'(accept ? acc_need : 5'd0) + SW'(bus.rd_credit_i);
    over       = (credit_sum > SW'(CAPACITY));
  end

  // State, credit and registered FIFO write port
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      lock      <= '0;
      rr_ptr    <= '0;
      credit    <= CW'(CAPACITY);
      err       <= 1'b0;
      stall     <= 1'b0;
      fifo_we   <= 1'b0;
      fifo_data <= '0;
      fifo_size <= '0;
      grant_id  <= '0;
    end else begin
      state   <= state_next;
      lock    <= lock_next;
      stall   <= (state_next == WAIT);
      credit  <= over ? CW'(CAPACITY) : CW'(credit_sum);
      fifo_we <= accept;
      if (over) begin
        err <= 1'b1;
      end
      if (accept) begin
        fifo_data <= data_arr[acc_id];
        fifo_size <= size_arr[acc_id];
        grant_id  <= 3'(acc_id);
        rr_ptr    <= IW'((32'(acc_id) + 1) % N_REQ);
      end
    end
  end

  assign bus.fifo_data_o  = fifo_data;
  assign bus.fifo_size_o  = fifo_size;
  assign bus.fifo_we_o    = fifo_we;
  assign bus.credit_o     = credit;
  assign bus.grant_id_o   = grant_id;
  assign bus.stall_o      = stall;
  assign bus.credit_err_o = err;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table plus multi-cycle corner sequences.
module tb_fifo_wr_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.N_REQ(4), .CW(7)) bus ();

  fifo_wr_arbiter #(.N_REQ(4), .CAPACITY(64), .CW(7)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] size;
    logic        rd;
    logic [3:0]  ready;
    logic        we;
    logic [3:0]  fsize;
    logic [2:0]  grant;
    logic [6:0]  credit;
    logic        stall;
  } vec_t;

  vec_t tbl [11];

  function automatic logic [255:0] pat(input int unsigned i);
    logic [255:0] r;
    r = '0;
    for (int unsigned w = 0; w < 16; w++) r[16*w +: 16] = 16'(i * 256 + w);
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n          = 1'b0;
    bus.req_valid    = '0;
    bus.req_size     = '0;
    bus.rd_credit_i  = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    // valid, size, rd | ready, we, fsize, grant, credit, stall
    tbl[0]  = '{4'b0001, 16'h0005, 1'b0, 4'b0001, 1'b0, 4'd0, 3'd0, 7'd64, 1'b0};
    tbl[1]  = '{4'b0000, 16'h0005, 1'b0, 4'b0000, 1'b1, 4'd5, 3'd0, 7'd59, 1'b0};
    tbl[2]  = '{4'b1111, 16'h1111, 1'b0, 4'b0010, 1'b0, 4'd5, 3'd0, 7'd59, 1'b0};
    tbl[3]  = '{4'b1111, 16'h1111, 1'b0, 4'b0100, 1'b1, 4'd1, 3'd1, 7'd58, 1'b0};
    tbl[4]  = '{4'b1111, 16'h1111, 1'b0, 4'b1000, 1'b1, 4'd1, 3'd2, 7'd57, 1'b0};
    tbl[5]  = '{4'b1111, 16'h1111, 1'b0, 4'b0001, 1'b1, 4'd1, 3'd3, 7'd56, 1'b0};
    tbl[6]  = '{4'b1111, 16'h1111, 1'b0, 4'b0010, 1'b1, 4'd1, 3'd0, 7'd55, 1'b0};
    tbl[7]  = '{4'b0000, 16'h1111, 1'b0, 4'b0000, 1'b1, 4'd1, 3'd1, 7'd54, 1'b0};
    tbl[8]  = '{4'b0000, 16'h1111, 1'b0, 4'b0000, 1'b0, 4'd1, 3'd1, 7'd54, 1'b0};
    tbl[9]  = '{4'b0000, 16'h1111, 1'b1, 4'b0000, 1'b0, 4'd1, 3'd1, 7'd54, 1'b0};
    tbl[10] = '{4'b0000, 16'h1111, 1'b0, 4'b0000, 1'b0, 4'd1, 3'd1, 7'd55, 1'b0};

    for (int unsigned i = 0; i < 4; i++) bus.req_data[256*i +: 256] = pat(i);

    // Reset values; ready stays low even with a valid request during reset
    do_reset();
    reset_n       = 1'b0;
    bus.req_valid = 4'b0001;
    #1;
    chk("rst_ready", 256'(bus.req_ready), 256'(4'b0000));
    tick();
    chk("rst_credit", 256'(bus.credit_o), 256'(7'd64));
    chk("rst_we", 256'(bus.fifo_we_o), 256'(1'b0));
    chk("rst_size", 256'(bus.fifo_size_o), 256'(4'd0));
    chk("rst_data", bus.fifo_data_o, 256'(0));
    chk("rst_grant", 256'(bus.grant_id_o), 256'(3'd0));
    chk("rst_stall", 256'(bus.stall_o), 256'(1'b0));
    chk("rst_err", 256'(bus.credit_err_o), 256'(1'b0));
    reset_n = 1'b1;

    // Table: single grant, round-robin rotation, credit return
    for (int r = 0; r < 11; r++) begin
      bus.req_valid   = tbl[r].valid;
      bus.req_size    = tbl[r].size;
      bus.rd_credit_i = tbl[r].rd;
      #1;
      chk($sformatf("t%0d_ready", r), 256'(bus.req_ready), 256'(tbl[r].ready));
      chk($sformatf("t%0d_we", r), 256'(bus.fifo_we_o), 256'(tbl[r].we));
      chk($sformatf("t%0d_fsize", r), 256'(bus.fifo_size_o), 256'(tbl[r].fsize));
      chk($sformatf("t%0d_grant", r), 256'(bus.grant_id_o), 256'(tbl[r].grant));
      chk($sformatf("t%0d_credit", r), 256'(bus.credit_o), 256'(tbl[r].credit));
      chk($sformatf("t%0d_stall", r), 256'(bus.stall_o), 256'(tbl[r].stall));
      if (tbl[r].we)
        chk($sformatf("t%0d_data", r), bus.fifo_data_o, pat(32'(tbl[r].grant)));
      tick();
    end

    // Head-of-line blocking: 16-word burst waits for credits, smaller burst not bypassed
    do_reset();
    bus.req_valid = 4'b0001;
    bus.req_size  = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("b_ready16", 256'(bus.req_ready), 256'(4'b0001));
      tick();
    end
    bus.req_size = 16'h0006;
    #1;
    chk("b_credit16", 256'(bus.credit_o), 256'(7'd16));
    chk("b_ready6", 256'(bus.req_ready), 256'(4'b0001));
    tick();
    bus.req_size = 16'h0000;
    #1;
    chk("b_credit10", 256'(bus.credit_o), 256'(7'd10));
    chk("b_enter_wait", 256'(bus.req_ready), 256'(4'b0000));
    tick();
    bus.req_valid = 4'b0011;
    bus.req_size  = 16'h0010;
    #1;
    chk("b_stall", 256'(bus.stall_o), 256'(1'b1));
    chk("b_no_bypass", 256'(bus.req_ready), 256'(4'b0000));
    bus.rd_credit_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("b_wait_ready", 256'(bus.req_ready), 256'(4'b0000));
      chk("b_wait_stall", 256'(bus.stall_o), 256'(1'b1));
      tick();
    end
    bus.rd_credit_i = 1'b0;
    #1;
    chk("b_credit_fit", 256'(bus.credit_o), 256'(7'd16));
    chk("b_grant_ready", 256'(bus.req_ready), 256'(4'b0001));
    tick();
    chk("b_credit0", 256'(bus.credit_o), 256'(7'd0));
    chk("b_we", 256'(bus.fifo_we_o), 256'(1'b1));
    chk("b_grant", 256'(bus.grant_id_o), 256'(3'd0));
    chk("b_fsize", 256'(bus.fifo_size_o), 256'(4'd0));
    chk("b_data", bus.fifo_data_o, pat(0));
    chk("b_stall_clear", 256'(bus.stall_o), 256'(1'b0));
    chk("b_r1_no_credit", 256'(bus.req_ready), 256'(4'b0000));

    // Accept and return in the same cycle at exact fit
    bus.req_valid   = 4'b0000;
    bus.rd_credit_i = 1'b1;
    tick();
    tick();
    tick();
    bus.req_valid = 4'b0001;
    bus.req_size  = 16'h0003;
    #1;
    chk("c_credit3", 256'(bus.credit_o), 256'(7'd3));
    chk("c_stall", 256'(bus.stall_o), 256'(1'b0));
    chk("c_ready", 256'(bus.req_ready), 256'(4'b0001));
    tick();
    bus.req_valid   = 4'b0000;
    bus.rd_credit_i = 1'b0;
    #1;
    chk("c_credit1", 256'(bus.credit_o), 256'(7'd1));
    chk("c_we", 256'(bus.fifo_we_o), 256'(1'b1));
    chk("c_fsize", 256'(bus.fifo_size_o), 256'(4'd3));

    // Return at full capacity saturates and sets the sticky error
    do_reset();
    bus.rd_credit_i = 1'b1;
    #1;
    chk("d_err_before", 256'(bus.credit_err_o), 256'(1'b0));
    tick();
    bus.rd_credit_i = 1'b0;
    #1;
    chk("d_credit_sat", 256'(bus.credit_o), 256'(7'd64));
    chk("d_err_set", 256'(bus.credit_err_o), 256'(1'b1));
    tick();
    tick();
    chk("d_err_sticky", 256'(bus.credit_err_o), 256'(1'b1));
    reset_n = 1'b0;
    tick();
    chk("d_err_reset", 256'(bus.credit_err_o), 256'(1'b0));
    reset_n = 1'b1;

    // Reset while waiting returns to IDLE with full credit
    do_reset();
    bus.req_valid = 4'b0001;
    bus.req_size  = 16'h0000;
    tick();
    tick();
    tick();
    tick();
    #1;
    chk("e_credit0", 256'(bus.credit_o), 256'(7'd0));
    chk("e_we", 256'(bus.fifo_we_o), 256'(1'b1));
    chk("e_enter_wait", 256'(bus.req_ready), 256'(4'b0000));
    tick();
    chk("e_stall", 256'(bus.stall_o), 256'(1'b1));
    chk("e_we_idle", 256'(bus.fifo_we_o), 256'(1'b0));
    reset_n = 1'b0;
    #1;
    chk("e_rst_ready", 256'(bus.req_ready), 256'(4'b0000));
    tick();
    chk("e_rst_credit", 256'(bus.credit_o), 256'(7'd64));
    chk("e_rst_stall", 256'(bus.stall_o), 256'(1'b0));
    chk("e_rst_we", 256'(bus.fifo_we_o), 256'(1'b0));
    chk("e_rst_ready2", 256'(bus.req_ready), 256'(4'b0000));
    reset_n = 1'b1;
    #1;
    chk("e_idle_ready", 256'(bus.req_ready), 256'(4'b0001));
    tick();
    chk("e_after_we", 256'(bus.fifo_we_o), 256'(1'b1));
    chk("e_after_credit", 256'(bus.credit_o), 256'(7'd48));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
